bcd_counter_display: RTL and testbench
======================================

# bcd_counter_display

Parametrised N-digit BCD up/down counter with an integrated time-multiplexed 7-segment driver, for the board-level display path. It replaces the fixed two-digit seconds counter: the digit count, tick rate and scan rate are parameters. It adds up/down counting, enable, synchronous clear, parallel BCD load, a wrap pulse and optional leading-zero blanking. Outputs drive the board's active-low anode and cathode lines directly.

## Interface
Parameters:
- NDIGITS, 4: number of BCD digits, legal range 1..8.
- TICK_DIV, 100_000_000: clk cycles per count tick, minimum 2.
- SCAN_DIV, 20_000: clk cycles each digit stays lit, minimum 1.
- BLANK_LZ, 1: 1 blanks leading zeros; digit 0 is never blanked.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  count enable; gates tick steps only.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear of the count.
- load  in  1  synchronous parallel load.
- load_val  in  4*NDIGITS  BCD load value; digit 0 in [3:0].
- count  out  4*NDIGITS  current BCD count; digit 0 in [3:0].
- wrap  out  1  one-cycle pulse on roll-over or roll-under.
- an  out  8  anode selects, active-low, one-cold.
- ca  out  8  cathodes, active-low; bit 7 = a … bit 1 = g, bit 0 = dp.

## Operation
- Tick divider:
  - tick_cnt counts 0..TICK_DIV-1 and free-runs, independent of en, clr and load.
  - tick is asserted for one clk when tick_cnt == TICK_DIV-1; tick_cnt then returns to 0.
- Count update priority, evaluated each clk edge: !rst_n > clr > load > (tick & en) > hold.
  - clr: count ← 0.
  - load: each load_val digit ≤ 9 is taken as-is. A digit > 9 is loaded as 0.
  - Step up: ripple-carry BCD increment; 9 → 0 carries into the next digit. All-9s → all-0s and wrap = 1.
  - Step down: BCD decrement; 0 → 9 borrows from the next digit. All-0s → all-9s and wrap = 1.
  - wrap is 0 in every other cycle, including clr and load cycles.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - On the terminal value, idx advances; it goes NDIGITS-1 → 0.
  - an[idx] = 0. All other bits, including bits ≥ NDIGITS, are 1.
- Segment map, with dp always off:
  - 0 = 0x03, 1 = 0x9F, 2 = 0x25, 3 = 0x0D, 4 = 0x99
  - 5 = 0x49, 6 = 0xC1, 7 = 0x1F, 8 = 0x01, 9 = 0x19
  - Blank = 0xFF.
- Blanking (BLANK_LZ = 1): a digit idx > 0 shows blank when it is 0 and every digit above it is 0.
- No latch or retained stale value on an undefined code; all case statements are fully specified.

## Timing
- Reset values: count = 0, wrap = 0, an = 0xFF, ca = 0xFF, tick_cnt = 0, scan_cnt = 0, idx = 0.
- First clk edge with rst_n = 1: an = 0xFE, ca = 0x03.
- count and wrap are registered. They change on the edge where tick & en (or clr/load) is sampled, so latency is 1 clk.
- an and ca are registered from idx and count, both updated on the same edge. A count change appears on ca one clk later if that digit is currently selected.
- Simultaneous events:
  - clr with load: clr wins.
  - load with tick & en: load wins and the step is lost; wrap = 0.
- Reset mid-operation: all state returns to reset values at the next edge. No pending step or wrap survives.
- en deasserted: the divider still runs. The next tick after re-enable steps normally; no catch-up steps.

## Structure
- Package seg7_pkg holds:
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - The localparam for digit width (4).
  - A function returning the BCD digit count width.
- Sub-module seg7_decoder: combinational 4-bit digit plus blank flag → 8-bit cathode pattern. It is instantiated once, after the digit mux.
- The top level holds the dividers, BCD counter chain, scan index, blanking logic and output registers.

## Test plan
Bench parameters: NDIGITS = 3, TICK_DIV = 4, SCAN_DIV = 2, BLANK_LZ = 1.
- Reset, then up = 1, en = 1 for 40 clk → count steps every 4 clk: 0x000, 0x001, … 0x009, 0x010. The digit-0 carry is correct.
- load_val = 0x999, then one tick up → count = 0x000 and wrap high for exactly 1 clk. A second tick down → 0x999 with a wrap pulse.
- load_val = 0x1A5 → count = 0x105: the invalid digit is forced to 0.
- clr, load and tick asserted in the same cycle → count = 0x000 and wrap = 0.
- count = 0x007, observe a full scan → an cycles FE, FD, FB. ca = 0x1F on FE and 0xFF on FD and FB (blanked).
- rst_n low for 1 clk while count = 0x456 mid-scan → next edge: count = 0, an = 0xFF, ca = 0xFF, wrap = 0.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg : digit width, active-low 7-segment patterns, width helper  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package seg7_pkg;

    localparam int DIGIT_W = 4;

    // Bit 7 = a ... bit 1 = g, bit 0 = dp; all active-low with dp off.
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'hC1;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h19;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic int bcd_width(input int ndigits);
        return ndigits * DIGIT_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_decoder : BCD digit plus blank flag to active-low cathodes      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_counter_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_counter_display : N-digit BCD up/down counter with multiplexed   |
// |                       active-low 7-segment driver                    |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module bcd_counter_display
    import seg7_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 20_000,
    parameter int BLANK_LZ = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         up,
    input  logic                         clr,
    input  logic                         load,
    input  logic [DIGIT_W*NDIGITS-1:0]   load_val,
    output logic [DIGIT_W*NDIGITS-1:0]   count,
    output logic                         wrap,
    output logic [7:0]                   an,
    output logic [7:0]                   ca
);

    localparam int CW = bcd_width(NDIGITS);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] C_SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [2:0]    C_IDX_LAST  = 3'(NDIGITS - 1);

    logic [TW-1:0]      r_tick_cnt_q, w_tick_cnt_d;
    logic [SW-1:0]      r_scan_cnt_q, w_scan_cnt_d;
    logic [2:0]         r_idx_q,      w_idx_d;
    logic [CW-1:0]      r_count_q,    w_count_d;
    logic               r_wrap_q,     w_wrap_d;
    logic [7:0]         r_an_q,       w_an_d;
    logic [7:0]         r_ca_q,       w_ca_d;

    logic               w_tick;
    logic [CW-1:0]      w_inc, w_dec, w_ldv;
    logic               w_carry, w_borrow;
    logic [3:0]         w_dig, w_ld_dig;
    logic [NDIGITS-1:0] w_lz;
    logic               w_lz_run;
    logic [3:0]         w_sel_digit;
    logic               w_sel_blank;

    always_comb begin
        w_tick       = (r_tick_cnt_q == C_TICK_LAST);
        w_tick_cnt_d = w_tick ? '0 : r_tick_cnt_q + 1'b1;

        w_scan_cnt_d = r_scan_cnt_q + 1'b1;
        w_idx_d      = r_idx_q;
        if (r_scan_cnt_q == C_SCAN_LAST) begin
            w_scan_cnt_d = '0;
            w_idx_d      = (r_idx_q == C_IDX_LAST) ? 3'd0 : r_idx_q + 3'd1;
        end
    end

    // Ripple carry/borrow chains plus load sanitising, digit 0 first.
    always_comb begin
        w_inc    = '0;
        w_dec    = '0;
        w_ldv    = '0;
        w_dig    = '0;
        w_ld_dig = '0;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            w_dig    = r_count_q[i*DIGIT_W +: DIGIT_W];
            w_ld_dig = load_val[i*DIGIT_W +: DIGIT_W];

            w_inc[i*DIGIT_W +: DIGIT_W] = w_dig;
            if (w_carry) begin
                if (w_dig >= 4'd9) begin
                    w_inc[i*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    w_inc[i*DIGIT_W +: DIGIT_W] = w_dig + 4'd1;
                    w_carry = 1'b0;
                end
            end

            w_dec[i*DIGIT_W +: DIGIT_W] = w_dig;
            if (w_borrow) begin
                if (w_dig == 4'd0) begin
                    w_dec[i*DIGIT_W +: DIGIT_W] = 4'd9;
                end else begin
                    w_dec[i*DIGIT_W +: DIGIT_W] = w_dig - 4'd1;
                    w_borrow = 1'b0;
                end
            end

            w_ldv[i*DIGIT_W +: DIGIT_W] = (w_ld_dig > 4'd9) ? 4'd0 : w_ld_dig;
        end
    end

    always_comb begin
        w_count_d = r_count_q;
        w_wrap_d  = 1'b0;
        if (clr) begin
            w_count_d = '0;
        end else if (load) begin
            w_count_d = w_ldv;
        end else if (w_tick && en) begin
            if (up) begin
                w_count_d = w_inc;
                w_wrap_d  = w_carry;
            end else begin
                w_count_d = w_dec;
                w_wrap_d  = w_borrow;
            end
        end
    end

    // w_lz[i] is set when digit i and every digit above it are zero.
    always_comb begin
        w_lz        = '0;
        w_lz_run    = 1'b1;
        w_sel_digit = '0;
        w_sel_blank = 1'b0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            w_lz_run = w_lz_run && (r_count_q[i*DIGIT_W +: DIGIT_W] == 4'd0);
            w_lz[i]  = w_lz_run;
        end
        for (int i = 0; i < NDIGITS; i++) begin
            if (r_idx_q == 3'(i)) begin
                w_sel_digit = r_count_q[i*DIGIT_W +: DIGIT_W];
                w_sel_blank = (BLANK_LZ != 0) && (i != 0) && w_lz[i];
            end
        end
        w_an_d = ~(8'd1 << r_idx_q);
    end

    seg7_decoder u_seg7_decoder (
        .i_digit (w_sel_digit),
        .i_blank (w_sel_blank),
        .o_seg   (w_ca_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt_q <= '0;
            r_scan_cnt_q <= '0;
            r_idx_q      <= '0;
            r_count_q    <= '0;
            r_wrap_q     <= 1'b0;
            r_an_q       <= 8'hFF;
            r_ca_q       <= 8'hFF;
        end else begin
            r_tick_cnt_q <= w_tick_cnt_d;
            r_scan_cnt_q <= w_scan_cnt_d;
            r_idx_q      <= w_idx_d;
            r_count_q    <= w_count_d;
            r_wrap_q     <= w_wrap_d;
            r_an_q       <= w_an_d;
            r_ca_q       <= w_ca_d;
        end
    end

    assign count = r_count_q;
    assign wrap  = r_wrap_q;
    assign an    = r_an_q;
    assign ca    = r_ca_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_counter_display.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_counter_display : scoreboard bench, 3 digits, fast dividers   |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_bcd_counter_display;

    localparam int ND = 3;
    localparam int TD = 4;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        rst_n, en, up, clr, load;
    logic [11:0] load_val;
    logic [11:0] count;
    logic        wrap;
    logic [7:0]  an, ca;

    always #5 clk = ~clk;

    bcd_counter_display #(
        .NDIGITS  (ND),
        .TICK_DIV (TD),
        .SCAN_DIV (SD),
        .BLANK_LZ (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
        .an       (an),
        .ca       (ca)
    );

    typedef struct {
        string       tag;
        logic [11:0] count;
        logic        wrap;
        logic [7:0]  an;
        logic [7:0]  ca;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   wrap_seen   = 0;

    // Reference model: decimal count value plus divider/scan state.
    int         m_val, m_tick, m_scan, m_idx;
    logic       m_wrap;
    logic [7:0] m_an, m_ca;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;
            3: return 8'h0D;  4: return 8'h99;  5: return 8'h49;
            6: return 8'hC1;  7: return 8'h1F;  8: return 8'h01;
            9: return 8'h19;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'(v / 100);
        return r;
    endfunction

    function automatic int sanitize(input logic [11:0] lv);
        int         v;
        int         p;
        logic [3:0] d;
        v = 0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            d = lv[i*4 +: 4];
            if (d <= 4'd9) v += int'(d) * p;
            p *= 10;
        end
        return v;
    endfunction

    task automatic model_edge();
        int   p;
        logic tick;
        if (!rst_n) begin
            m_val = 0; m_tick = 0; m_scan = 0; m_idx = 0;
            m_wrap = 1'b0; m_an = 8'hFF; m_ca = 8'hFF;
            return;
        end
        p = (m_idx == 0) ? 1 : (m_idx == 1) ? 10 : 100;
        m_an = 8'hFF;
        m_an[m_idx] = 1'b0;
        m_ca = (m_idx > 0 && m_val < p) ? 8'hFF : seg_of((m_val / p) % 10);
        tick   = (m_tick == TD - 1);
        m_tick = tick ? 0 : m_tick + 1;
        if (m_scan == SD - 1) begin
            m_scan = 0;
            m_idx  = (m_idx == ND - 1) ? 0 : m_idx + 1;
        end else begin
            m_scan++;
        end
        m_wrap = 1'b0;
        if (clr) begin
            m_val = 0;
        end else if (load) begin
            m_val = sanitize(load_val);
        end else if (tick && en) begin
            if (up) begin
                m_wrap = (m_val == 999);
                m_val  = (m_val + 1) % 1000;
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + 999) % 1000;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_edge();
        e.tag   = tag;
        e.count = to_bcd(m_val);
        e.wrap  = m_wrap;
        e.an    = m_an;
        e.ca    = m_ca;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (wrap === 1'b1) wrap_seen++;
        chk({e.tag, " count"}, 32'(count), 32'(e.count));
        chk({e.tag, " wrap"},  32'(wrap),  32'(e.wrap));
        chk({e.tag, " an"},    32'(an),    32'(e.an));
        chk({e.tag, " ca"},    32'(ca),    32'(e.ca));
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic align_tick(input string tag);
        for (int i = 0; i < TD && m_tick != TD - 1; i++) step(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] seen;
        rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        m_val = 0; m_tick = 0; m_scan = 0; m_idx = 0;
        m_wrap = 1'b0; m_an = 8'hFF; m_ca = 8'hFF;

        run(2, "reset");
        chk("reset count", 32'(count), 32'h000);
        chk("reset an",    32'(an),    32'hFF);
        chk("reset ca",    32'(ca),    32'hFF);

        rst_n = 1'b1; en = 1'b1; up = 1'b1;
        step("first");
        chk("first an", 32'(an), 32'hFE);
        chk("first ca", 32'(ca), 32'h03);
        run(39, "upcount");
        chk("upcount 40clk", 32'(count), 32'h010);

        en = 1'b0; run(6, "paused");
        en = 1'b1; run(8, "resumed");

        load = 1'b1; load_val = 12'h999; step("load999");
        load = 1'b0; wrap_seen = 0;
        run(4, "wrap_up");
        chk("wrap_up count", 32'(count), 32'h000);
        chk("wrap_up pulses", 32'(wrap_seen), 32'd1);
        up = 1'b0; wrap_seen = 0;
        run(4, "wrap_dn");
        chk("wrap_dn count", 32'(count), 32'h999);
        chk("wrap_dn pulses", 32'(wrap_seen), 32'd1);

        en = 1'b0; load = 1'b1; load_val = 12'h1A5; step("load_bad");
        load = 1'b0;
        chk("load_bad count", 32'(count), 32'h105);

        en = 1'b1; up = 1'b1;
        align_tick("align1");
        load = 1'b1; load_val = 12'h123; step("load_tick");
        load = 1'b0;
        chk("load_tick count", 32'(count), 32'h123);
        chk("load_tick wrap",  32'(wrap),  32'h0);

        align_tick("align2");
        clr = 1'b1; load = 1'b1; load_val = 12'h999; step("clr_all");
        clr = 1'b0; load = 1'b0;
        chk("clr_all count", 32'(count), 32'h000);
        chk("clr_all wrap",  32'(wrap),  32'h0);

        en = 1'b0; load = 1'b1; load_val = 12'h007; step("load7");
        load = 1'b0;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            step("scan7");
            if (an === 8'hFE) begin
                seen[0] = 1'b1;
                chk("scan7 ca d0", 32'(ca), 32'h1F);
            end else if (an === 8'hFD || an === 8'hFB) begin
                seen[(an === 8'hFD) ? 1 : 2] = 1'b1;
                chk("scan7 ca blank", 32'(ca), 32'hFF);
            end
        end
        chk("scan7 anodes", 32'(seen), 32'h7);

        load = 1'b1; load_val = 12'h456; step("load456");
        load = 1'b0; en = 1'b1;
        run(3, "midscan");
        rst_n = 1'b0; step("mid_reset");
        chk("mid_reset count", 32'(count), 32'h000);
        chk("mid_reset an",    32'(an),    32'hFF);
        chk("mid_reset ca",    32'(ca),    32'hFF);
        chk("mid_reset wrap",  32'(wrap),  32'h0);
        rst_n = 1'b1; step("after_reset");
        chk("after_reset an", 32'(an), 32'hFE);
        chk("after_reset ca", 32'(ca), 32'h03);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
